// File: rtl/bus_pkg.sv
// Shared definitions for the 128-bit external line bus and the main memory controller.
package bus_pkg;
  localparam int BUS_DATA_WIDTH = 128;
  localparam int LINE_WORDS     = 4;
  localparam int WORD_WIDTH     = 32;

  typedef enum logic [1:0] {
    MEMC_IDLE = 2'd0,
    MEMC_WAIT = 2'd1,
    MEMC_RESP = 2'd2,
    MEMC_GAP  = 2'd3
  } memc_state_t;

  typedef struct packed {
    logic                      we;
    logic [BUS_DATA_WIDTH-1:0] data;
  } line_req_t;

  function automatic logic [LINE_WORDS-1:0] lane_mask(input logic [1:0] lane);
    lane_mask       = '0;
    lane_mask[lane] = 1'b1;
  endfunction
endpackage

// File: rtl/mem_line_array.sv
// Single-port line array with per-32-bit-lane write enables and a registered read port.
module mem_line_array
  import bus_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                      clk,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [LINE_WORDS-1:0]     lane_we,
  input  logic [BUS_DATA_WIDTH-1:0] wdata,
  output logic [BUS_DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [BUS_DATA_WIDTH-1:0] mem [DEPTH];

  // Read-first: a write cycle returns the previous contents, which the controller discards.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LINE_WORDS; l++)
      if (lane_we[l])
        mem[addr][l*WORD_WIDTH +: WORD_WIDTH] <= wdata[l*WORD_WIDTH +: WORD_WIDTH];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/main_memory_ctrl.sv
// Line-granular main memory: one bus request at a time after a programmable latency,
// plus a word-wide preload port that writes a single lane of a line.
module main_memory_ctrl
  import bus_pkg::*;
#(
  parameter int BUS_ADDRESS_WIDTH    = 20,
  parameter int BUS_DATA_WIDTH_SHIFT = 4,
  parameter int MEM_LINE_SHIFT       = 12,
  parameter int LATENCY              = 4
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] bus_addr_i,
  input  logic [BUS_DATA_WIDTH-1:0]                     bus_data_i,
  input  logic                                          bus_we_i,
  input  logic                                          bus_valid_i,
  output logic [BUS_DATA_WIDTH-1:0]                     bus_data_o,
  output logic                                          bus_valid_o,
  input  logic                                          load_en_i,
  input  logic [BUS_ADDRESS_WIDTH-1:2]                  load_addr_i,
  input  logic [WORD_WIDTH-1:0]                         load_data_i,
  output logic                                          load_busy_o
);
  localparam int         IDX_LO   = BUS_DATA_WIDTH_SHIFT;
  localparam int         IDX_HI   = BUS_DATA_WIDTH_SHIFT + MEM_LINE_SHIFT - 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  memc_state_t               state, state_next;
  logic [3:0]                cnt;
  logic [MEM_LINE_SHIFT-1:0] req_idx;
  line_req_t                 req;
  logic                      accept, access, load_go;
  logic [MEM_LINE_SHIFT-1:0] arr_addr;
  logic [LINE_WORDS-1:0]     arr_we;
  logic [BUS_DATA_WIDTH-1:0] arr_wdata, arr_rdata;

  // Bits above the line index alias onto the same line.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus_addr_i[BUS_ADDRESS_WIDTH-1:IDX_HI+1],
                            load_addr_i[BUS_ADDRESS_WIDTH-1:IDX_HI+1]};

  // A load strobe in IDLE takes the array this cycle; the request waits one cycle.
  assign accept = (state == MEMC_IDLE) && bus_valid_i && !load_en_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= MEMC_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MEMC_IDLE: if (accept) state_next = MEMC_WAIT;
      MEMC_WAIT: if (cnt == 4'd0) state_next = MEMC_RESP;
      MEMC_RESP: state_next = MEMC_GAP;
      MEMC_GAP:  state_next = MEMC_IDLE;
      default:   state_next = MEMC_IDLE;
    endcase
  end

  always_comb begin
    load_go     = 1'b0;
    access      = 1'b0;
    load_busy_o = 1'b1;
    case (state)
      MEMC_IDLE: begin
        load_busy_o = 1'b0;
        load_go     = load_en_i;
      end
      MEMC_WAIT: access = (cnt == 4'd0);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                                 cnt <= 4'd0;
    else if (accept)                           cnt <= CNT_INIT;
    else if (state == MEMC_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_idx  <= bus_addr_i[IDX_HI:IDX_LO];
      req.we   <= bus_we_i;
      req.data <= bus_data_i;
    end
  end

  // Writes commit on the last WAIT edge; reset on that edge suppresses them.
  always_comb begin
    arr_addr  = req_idx;
    arr_wdata = req.data;
    arr_we    = '0;
    if (load_go) begin
      arr_addr  = load_addr_i[IDX_HI:IDX_LO];
      arr_wdata = {LINE_WORDS{load_data_i}};
      arr_we    = lane_mask(load_addr_i[BUS_DATA_WIDTH_SHIFT-1:2]);
    end else if (access && req.we) begin
      arr_we = '1;
    end
    if (rst_i) arr_we = '0;
  end

  mem_line_array #(.ADDR_W(MEM_LINE_SHIFT)) u_array (
    .clk     (clk_i),
    .addr    (arr_addr),
    .lane_we (arr_we),
    .wdata   (arr_wdata),
    .rdata   (arr_rdata)
  );

  // Read data lands in arr_rdata during RESP; register it with the pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus_valid_o <= 1'b0;
      bus_data_o  <= '0;
    end else begin
      bus_valid_o <= (state == MEMC_RESP);
      bus_data_o  <= (state == MEMC_RESP && !req.we) ? arr_rdata : '0;
    end
  end
endmodule
